sim_video_sink: RTL and testbench
=================================

Name: sim_video_sink

Overview:
- Receive-side counterpart to the simulated video source; consumes one 8-bit video stream frame over the vtdata/vtvalid/vtready/vtlast handshake.
- Drives vtready with a deterministic backpressure pattern.
- Checks every accepted beat against the expected {row[3:0],col[3:0]} test pattern and checks the vtlast position.
- Reports per-frame error counts and a pass flag. Used as the testbench/loopback endpoint for stream-processing blocks.

Parameters:
- WIDTH, 16: pixels per line (2..1023).
- HEIGHT, 10: lines per frame (1..1023).
- READY_MASK, 8'hFF: 8-bit backpressure pattern, rotated right by one bit each cycle in RECV; vtready = current bit 0. 8'hFF means no backpressure.
- TIMEOUT, 64: stall-cycle limit; used only with SINK_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to receive one frame.
- vtdata  in  8  stream pixel.
- vtvalid  in  1  source data valid.
- vtlast  in  1  source end-of-frame marker.
- vtready  out  1  sink ready (registered).
- busy  out  1  high while in RECV.
- done  out  1  one-cycle pulse at end of frame check.
- frame_ok  out  1  result of the last completed frame.
- data_err  out  16  count of accepted beats with a vtdata mismatch.
- last_err  out  16  count of accepted beats where vtlast differs from expected.
- timeout  out  1  stall timeout flag (see Optional Feature).

Behaviour:
- Reset (rstn=0, asynchronous) sets:
  - state=IDLE
  - vtready=0, busy=0, done=0, frame_ok=0, timeout=0
  - data_err=0, last_err=0
  - column/row counters ex=ey=0
  - mask register = READY_MASK
  Reset mid-frame abandons the frame immediately; no done pulse.
- Beat accepted only when vtvalid && vtready in the same cycle. The source must hold vtdata/vtlast stable while vtvalid && !vtready.
- IDLE:
  - vtready=0.
  - On start: clear data_err, last_err, ex, ey, timeout; load mask=READY_MASK; set vtready=READY_MASK[0], busy=1; go to RECV (one-cycle latency from start to first possible ready).
- RECV:
  - Each cycle the mask rotates right by 1; vtready <= next mask[0].
  - On an accepted beat:
    - Expected data = {ey[3:0],ex[3:0]}; any mismatch increments data_err.
    - Expected last = (ey==HEIGHT-1 && ex==WIDTH-1); vtlast != expected last increments last_err.
    - If both mismatch in the same beat, both counters increment.
    - ex advances to ex+1, wrapping to 0 at WIDTH-1; ey increments on the ex wrap.
  - Counters saturate at 16'hFFFF and never wrap.
  - Frame end is the accepted beat with expected last, regardless of vtlast. Next cycle: state=DONE, vtready=0.
  - An early vtlast only counts an error; reception continues.
  - start in RECV is ignored.
- DONE (one cycle):
  - done=1, busy=0.
  - frame_ok = (data_err==0 && last_err==0 && !timeout), using counts that include the final beat.
  - Then IDLE.
- frame_ok, data_err and last_err hold until the next accepted start.
- start asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.

Optional Feature:
- SINK_TIMEOUT_EN defined:
  - A 16-bit stall counter is cleared on each accepted beat and on entering RECV.
  - It increments every RECV cycle without an accepted beat.
  - When it reaches TIMEOUT: set timeout=1, go to DONE (done pulse, frame_ok=0).
  - timeout holds until the next start.
- Not defined: no stall counter; timeout tied to 0; RECV waits indefinitely.

Test Plan:
- Reset, start, ideal source sending 160 beats {y,x} with vtlast on beat 160, READY_MASK=8'hFF -> vtready high every RECV cycle, done after 160 accepts, data_err=0, last_err=0, frame_ok=1.
- READY_MASK=8'b10101010 with an always-valid source -> vtready toggles every cycle, no beat accepted while vtready=0, 160 accepts, frame_ok=1.
- Corrupt beat 17 (expect 8'h10, send 8'h11) -> data_err=1, last_err=0, frame_ok=0.
- vtlast asserted on beat 80 and missing on beat 160 -> last_err=2, done still after beat 160, frame_ok=0.
- Pull rstn low at beat 50 -> all outputs 0 immediately, no done pulse; a new start then completes a clean frame with frame_ok=1.
- SINK_TIMEOUT_EN, TIMEOUT=64, source stops after beat 20 -> timeout=1 and done on the 64th stalled cycle, frame_ok=0; without the macro -> busy stays 1.

Source files
------------

// File: rtl/sim_video_sink.sv
// rtl/sim_video_sink.sv - video stream sink that checks a {row,col} test pattern frame; optional SINK_TIMEOUT_EN stall timeout
module sim_video_sink #(
    parameter int          WIDTH      = 16,
    parameter int          HEIGHT     = 10,
    parameter logic [7:0]  READY_MASK = 8'hFF,
    parameter int          TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  vtdata,
    input  logic        vtvalid,
    input  logic        vtlast,
    output logic        vtready,
    output logic        busy,
    output logic        done,
    output logic        frame_ok,
    output logic [15:0] data_err,
    output logic [15:0] last_err,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [9:0] EX_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] EY_LAST = 10'(HEIGHT - 1);

    state_t      state_q,    state_d;
    logic [7:0]  mask_q,     mask_d;
    logic        vtready_q,  vtready_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        frame_ok_q, frame_ok_d;
    logic [15:0] data_err_q, data_err_d;
    logic [15:0] last_err_q, last_err_d;
    logic [9:0]  ex_q,       ex_d;
    logic [9:0]  ey_q,       ey_d;
`ifdef SINK_TIMEOUT_EN
    logic        timeout_q,  timeout_d;
    logic [15:0] stall_q,    stall_d;
`endif

    logic       accept;
    logic       exp_last;
    logic [7:0] exp_data;
    logic       end_frame;

    // Error counters stick at all-ones instead of wrapping back to a clean-looking value.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state logic: handshake acceptance, pattern checking, position tracking and frame end.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        vtready_d  = vtready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        frame_ok_d = frame_ok_q;
        data_err_d = data_err_q;
        last_err_d = last_err_q;
        ex_d       = ex_q;
        ey_d       = ey_q;
`ifdef SINK_TIMEOUT_EN
        timeout_d  = timeout_q;
        stall_d    = stall_q;
`endif
        end_frame  = 1'b0;
        accept     = (state_q == S_RECV) && vtvalid && vtready_q;
        exp_last   = (ey_q == EY_LAST) && (ex_q == EX_LAST);
        exp_data   = {ey_q[3:0], ex_q[3:0]};

        case (state_q)
            S_IDLE: begin
                vtready_d = 1'b0;
                busy_d    = 1'b0;
                if (start) begin
                    data_err_d = 16'd0;
                    last_err_d = 16'd0;
                    ex_d       = 10'd0;
                    ey_d       = 10'd0;
                    mask_d     = READY_MASK;
                    vtready_d  = READY_MASK[0];
                    busy_d     = 1'b1;
                    state_d    = S_RECV;
`ifdef SINK_TIMEOUT_EN
                    timeout_d  = 1'b0;
                    stall_d    = 16'd0;
`endif
                end
            end
            S_RECV: begin
                // vtready always mirrors bit 0 of the rotating mask.
                mask_d    = {mask_q[0], mask_q[7:1]};
                vtready_d = mask_d[0];
                if (accept) begin
                    if (vtdata != exp_data) begin
                        data_err_d = sat_inc(data_err_q);
                    end
                    if (vtlast != exp_last) begin
                        last_err_d = sat_inc(last_err_q);
                    end
                    if (ex_q == EX_LAST) begin
                        ex_d = 10'd0;
                        ey_d = ey_q + 10'd1;
                    end else begin
                        ex_d = ex_q + 10'd1;
                    end
                    // The frame ends on the expected last position, whatever vtlast said.
                    if (exp_last) begin
                        end_frame = 1'b1;
                    end
                end
`ifdef SINK_TIMEOUT_EN
                stall_d = accept ? 16'd0 : stall_q + 16'd1;
                if (!accept && (stall_d == 16'(TIMEOUT))) begin
                    timeout_d = 1'b1;
                    end_frame = 1'b1;
                end
`endif
                if (end_frame) begin
                    state_d   = S_DONE;
                    vtready_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
`ifdef SINK_TIMEOUT_EN
                    frame_ok_d = (data_err_d == 16'd0) && (last_err_d == 16'd0) && !timeout_d;
`else
                    frame_ok_d = (data_err_d == 16'd0) && (last_err_d == 16'd0);
`endif
                end
            end
            S_DONE: begin
                vtready_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                vtready_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            mask_q     <= READY_MASK;
            vtready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frame_ok_q <= 1'b0;
            data_err_q <= 16'd0;
            last_err_q <= 16'd0;
            ex_q       <= 10'd0;
            ey_q       <= 10'd0;
`ifdef SINK_TIMEOUT_EN
            timeout_q  <= 1'b0;
            stall_q    <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            vtready_q  <= vtready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            frame_ok_q <= frame_ok_d;
            data_err_q <= data_err_d;
            last_err_q <= last_err_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
`ifdef SINK_TIMEOUT_EN
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
`endif
        end
    end

    assign vtready  = vtready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign frame_ok = frame_ok_q;
    assign data_err = data_err_q;
    assign last_err = last_err_q;
`ifdef SINK_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_sim_video_sink.sv
// tb/tb_sim_video_sink.sv - scoreboard bench for sim_video_sink
module tb_sim_video_sink;

    localparam logic [7:0] BP_MASK = 8'hAA;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [7:0]  vtdata = 8'd0;
    logic        vtvalid = 1'b0;
    logic        vtlast = 1'b0;

    logic        vtready_a, busy_a, done_a, frame_ok_a, timeout_a;
    logic [15:0] data_err_a, last_err_a;
    logic        vtready_b, busy_b, done_b, frame_ok_b, timeout_b;
    logic [15:0] data_err_b, last_err_b;

    int total = 0;
    int bad = 0;
    int acc_a = 0;
    int acc_b = 0;

    typedef struct {
        int sel;
        int de;
        int le;
        int ok;
        int to;
        int acc;
    } exp_t;
    exp_t sb[$];

    sim_video_sink #(.WIDTH(16), .HEIGHT(10), .READY_MASK(8'hFF), .TIMEOUT(64)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start_a),
        .vtdata(vtdata), .vtvalid(vtvalid), .vtlast(vtlast),
        .vtready(vtready_a), .busy(busy_a), .done(done_a), .frame_ok(frame_ok_a),
        .data_err(data_err_a), .last_err(last_err_a), .timeout(timeout_a)
    );

    sim_video_sink #(.WIDTH(16), .HEIGHT(10), .READY_MASK(BP_MASK), .TIMEOUT(64)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start_b),
        .vtdata(vtdata), .vtvalid(vtvalid), .vtlast(vtlast),
        .vtready(vtready_b), .busy(busy_b), .done(done_b), .frame_ok(frame_ok_b),
        .data_err(data_err_b), .last_err(last_err_b), .timeout(timeout_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: counts accepted beats and checks each done pulse against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            acc_a = 0;
            acc_b = 0;
        end else begin
            if (start_a) acc_a = 0;
            if (start_b) acc_b = 0;
            if (vtvalid && vtready_a) acc_a++;
            if (vtvalid && vtready_b) acc_b++;
            if (done_a || done_b) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.sel == 0) begin
                        chk("done_a", int'(done_a), 1);
                        chk("busy_a_at_done", int'(busy_a), 0);
                        chk("data_err_a", int'(data_err_a), e.de);
                        chk("last_err_a", int'(last_err_a), e.le);
                        chk("frame_ok_a", int'(frame_ok_a), e.ok);
                        chk("timeout_a", int'(timeout_a), e.to);
                        chk("accepts_a", acc_a, e.acc);
                    end else begin
                        chk("done_b", int'(done_b), 1);
                        chk("busy_b_at_done", int'(busy_b), 0);
                        chk("data_err_b", int'(data_err_b), e.de);
                        chk("last_err_b", int'(last_err_b), e.le);
                        chk("frame_ok_b", int'(frame_ok_b), e.ok);
                        chk("timeout_b", int'(timeout_b), e.to);
                        chk("accepts_b", acc_b, e.acc);
                    end
                end
            end
        end
    end

    task automatic push(input int sel, input int de, input int le, input int ok, input int to, input int acc);
        exp_t e;
        e.sel = sel; e.de = de; e.le = le; e.ok = ok; e.to = to; e.acc = acc;
        sb.push_back(e);
    endtask

    // Ends at the negedge of the first RECV cycle.
    task automatic start_frame(input int sel);
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("busy_after_start", (sel == 0) ? int'(busy_a) : int'(busy_b), 1);
    endtask

    // Always-valid source sending n beats of the {row,col} pattern; beat numbers are 1-based.
    task automatic send(input int sel, input int n, input int bad_beat,
                        input int last1, input int last2, input int abort_at);
        int idx = 0;
        int k = 0;
        bit stop = 1'b0;
        logic rdy;
        logic [7:0] pix;
        while (idx < n && !stop && k < 2000) begin
            pix = {4'(idx / 16), 4'(idx % 16)};
            if (idx + 1 == bad_beat) pix = pix ^ 8'h01;
            vtdata  = pix;
            vtvalid = 1'b1;
            vtlast  = (idx + 1 == last1) || (idx + 1 == last2);
            if (sel == 1) chk("bp_vtready", int'(vtready_b), int'(BP_MASK[k % 8]));
            rdy = (sel == 0) ? vtready_a : vtready_b;
            if (abort_at != 0 && idx == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("abort_vtready", int'(vtready_a), 0);
                chk("abort_busy", int'(busy_a), 0);
                chk("abort_done", int'(done_a), 0);
                chk("abort_frame_ok", int'(frame_ok_a), 0);
                chk("abort_data_err", int'(data_err_a), 0);
                chk("abort_last_err", int'(last_err_a), 0);
                chk("abort_timeout", int'(timeout_a), 0);
                stop = 1'b1;
            end else begin
                @(negedge clk);
                if (rdy) idx++;
                k++;
            end
        end
        if (k >= 2000) chk("send_budget", k, 0);
        vtvalid = 1'b0;
        vtlast  = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int c = 0;
        while (c < 100 && !((sel == 0) ? done_a : done_b)) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", int'((sel == 0) ? done_a : done_b), 1);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_vtready", int'(vtready_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_frame_ok", int'(frame_ok_a), 0);
        chk("rst_data_err", int'(data_err_a), 0);
        chk("rst_last_err", int'(last_err_a), 0);
        chk("rst_timeout", int'(timeout_a), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Clean frame, no backpressure.
        push(0, 0, 0, 1, 0, 160);
        start_frame(0);
        send(0, 160, 0, 160, 0, 0);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("hold_frame_ok", int'(frame_ok_a), 1);
        chk("hold_busy", int'(busy_a), 0);

        // Alternating backpressure.
        push(1, 0, 0, 1, 0, 160);
        start_frame(1);
        send(1, 160, 0, 160, 0, 0);
        wait_done(1);

        // Beat 17 carries 8'h11 instead of 8'h10.
        push(0, 1, 0, 0, 0, 160);
        start_frame(0);
        send(0, 160, 17, 160, 0, 0);
        wait_done(0);

        // vtlast early on beat 80 and missing on beat 160.
        push(0, 0, 2, 0, 0, 160);
        start_frame(0);
        send(0, 160, 0, 80, 0, 0);
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("hold_last_err", int'(last_err_a), 2);

        // Reset at beat 50 abandons the frame without a done pulse.
        start_frame(0);
        send(0, 160, 0, 160, 0, 50);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_abort_busy", int'(busy_a), 0);
        push(0, 0, 0, 1, 0, 160);
        start_frame(0);
        send(0, 160, 0, 160, 0, 0);
        wait_done(0);

        // Source stalls after beat 20.
        start_frame(0);
`ifdef SINK_TIMEOUT_EN
        push(0, 0, 0, 0, 1, 20);
        send(0, 20, 0, 160, 0, 0);
        wait_done(0);
        chk("timeout_hold", int'(timeout_a), 1);
`else
        send(0, 20, 0, 160, 0, 0);
        repeat (100) @(negedge clk);
        chk("stall_busy", int'(busy_a), 1);
        chk("stall_timeout", int'(timeout_a), 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
`endif
        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
